nrz_symbol_tx: RTL and testbench
================================

# nrz_symbol_tx

Transmit-side stimulus generator for the digital CDR: produces a baud-rate NRZ symbol stream as 8-bit signed samples, in the same format the CDR receive path takes on its input. Symbol timing comes from a fractional NCO, so the data rate can be offset from the receiver nominal to exercise frequency tracking. Data comes from a selectable pattern source. A 2-tap post-cursor FIR adds controlled ISI or de-emphasis. Instantiated in loopback/BIST wrappers and test harnesses upstream of the CDR.

## Interface
Parameters:
- PHASE_BITS, 32, NCO accumulator width
- PRBS7_SEED, 7'h7F, PRBS7 reset state
- PRBS15_SEED, 15'h7FFF, PRBS15 reset state

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  run enable
- fcw  in  PHASE_BITS  symbol-rate frequency control word (unsigned)
- pat_sel  in  2  00 PRBS7, 01 PRBS15, 10 clock pattern (1010…), 11 fixed word
- fix_word  in  16  fixed pattern, sent MSB first
- amp  in  7  unsigned main-cursor magnitude
- c1  in  4  signed post-cursor tap, units of amp/8, range −8..7
- inj_err  in  1  error-injection request pulse
- sym_en  out  1  one-cycle strobe; high in the first cycle of each new symbol
- tx_bit  out  1  current transmitted bit
- y_n  out  8  signed sample of current symbol

## Operation
- NCO: add = {0,phase} + {0,fcw}, width PHASE_BITS+1. When en=1: phase <= add[PHASE_BITS-1:0], and boundary = add[PHASE_BITS]. When en=0: phase holds, no boundary. At most one symbol per clock.
- On boundary, only the selected generator advances one step:
  - PRBS7: x^7+x^6+1. bit = s[6]; s <= {s[5:0], s[6]^s[5]}.
  - PRBS15: x^15+x^14+1. bit = s[14]; s <= {s[13:0], s[14]^s[13]}.
  - Clock: toggle flop, reset 0. First emitted bit is 1.
  - Fixed: 4-bit index, reset 15. bit = fix_word[idx]; idx decrements and wraps 0→15.
- Unselected generators hold their state. A pat_sel change takes effect at the next boundary, and the newly selected source resumes from its held state.
- Error injection:
  - inj_err=1 sets a pending flag.
  - At the next boundary, the emitted bit is inverted and the flag is cleared. Generator state is unaffected.
  - inj_err in a boundary cycle applies to that boundary.
  - Repeated pulses while pending have no extra effect.
- Level mapping:
  - d = tx_bit ? +1 : −1.
  - main = d·amp.
  - post = (c1·d_prev·amp) >>> 3, arithmetic (floor).
  - y = main + post, computed at 13-bit signed, then saturated to [−128, 127].
  - d_prev is the previous symbol's d. d_prev is treated as 0 for the first symbol after reset, via a prev_valid flag.
- amp, c1 and fix_word are sampled at boundaries only.

## Timing
- Boundary is decided combinationally in cycle k. sym_en, tx_bit and y_n are all registered and change together at the edge ending cycle k. Latency from the NCO carry to the outputs is 1 cycle.
- sym_en is high for exactly one cycle per symbol. Between boundaries, tx_bit and y_n hold.
- en=0: outputs hold their last values, and sym_en=0.
- Reset values: phase=0, LFSRs=seeds, clock flop=0, idx=15, pending=0, prev_valid=0, sym_en=0, tx_bit=0, y_n=0.
- rst_n assertion mid-symbol clears everything immediately, asynchronously. After release, the sequence restarts from the seeds.
- fcw=0 gives no boundaries. fcw=all-ones gives no boundary in the first enabled cycle, then a boundary every cycle.

## Structure
- Shared package cdr_pkg holds:
  - the pat_sel encoding constants,
  - PRBS tap positions and default seeds,
  - the sample width (8).
- One sub-module, prbs_gen, parameterised by width, tap and seed, with an advance enable. Instantiated twice.
- NCO, fixed/clock sources, injection and FIR stay in the top module.

## Test plan
- Reset, en=1, fcw=32'h4000_0000, PRBS7, amp=64, c1=0 → first sym_en on the 4th enabled cycle, then every 4 cycles. Bits match the PRBS7 model with period 127. y_n ∈ {+64, −64}.
- Clock pattern, amp=64, c1=−2 → first symbol y_n=+64 (no post-cursor). After that, y_n alternates +80/−80.
- Fixed 16'hF000, amp=127, c1=7 → run of ones saturates at +127. The first 0 after a 1 gives −16. Following zeros saturate at −128. Pattern repeats every 16 symbols.
- PRBS15, inj_err pulse mid-symbol → exactly one inverted bit at the next boundary versus the model. Later bits match the unmodified sequence. inj_err in a boundary cycle inverts that boundary's bit.
- Mid-run en=0 for 10 cycles → no sym_en and y_n held. After re-enabling, boundary spacing continues from the frozen phase. rst_n pulse mid-symbol → outputs 0 immediately, and PRBS restarts from the seed.
- fcw=32'hFFFF_FFFF → sym_en high every cycle from the second enabled cycle. pat_sel switched 00→01→00 mid-run → PRBS7 resumes exactly where it stopped.

Source files
------------

// File: rtl/cdr_pkg.sv
// Shared constants for the CDR test-path blocks: pattern select encoding,
// PRBS polynomial taps/seeds, sample width and the output saturator.
package cdr_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned ACC_W    = 13;

  typedef enum logic [1:0] {
    PAT_PRBS7  = 2'b00,
    PAT_PRBS15 = 2'b01,
    PAT_CLOCK  = 2'b10,
    PAT_FIXED  = 2'b11
  } pat_sel_e;

  // Feedback is s[W-1] ^ s[TAP]
  localparam int unsigned PRBS7_W    = 7;
  localparam int unsigned PRBS7_TAP  = 5;
  localparam int unsigned PRBS15_W   = 15;
  localparam int unsigned PRBS15_TAP = 13;

  localparam logic [PRBS7_W-1:0]  PRBS7_SEED_DEF  = 7'h7F;
  localparam logic [PRBS15_W-1:0] PRBS15_SEED_DEF = 15'h7FFF;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(128);

  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [ACC_W-1:0] v);
    logic signed [SAMPLE_W-1:0] r;
    if (v > SAT_MAX)      r = SAMPLE_W'(SAT_MAX);
    else if (v < SAT_MIN) r = SAMPLE_W'(SAT_MIN);
    else                  r = SAMPLE_W'(v);
    return r;
  endfunction

endpackage

// File: rtl/nrz_symbol_tx_if.sv
// Configuration and sample-stream bundle between a harness and nrz_symbol_tx.
interface nrz_symbol_tx_if #(
  parameter int unsigned PHASE_BITS = 32
);
  import cdr_pkg::*;

  logic                       en;
  logic [PHASE_BITS-1:0]      fcw;
  pat_sel_e                   pat_sel;
  logic [15:0]                fix_word;
  logic [6:0]                 amp;
  logic signed [3:0]          c1;
  logic                       inj_err;
  logic                       sym_en;
  logic                       tx_bit;
  logic signed [SAMPLE_W-1:0] y_n;

  modport master (
    output en, fcw, pat_sel, fix_word, amp, c1, inj_err,
    input  sym_en, tx_bit, y_n
  );

  modport slave (
    input  en, fcw, pat_sel, fix_word, amp, c1, inj_err,
    output sym_en, tx_bit, y_n
  );

endinterface

// File: rtl/prbs_gen.sv
// Fibonacci LFSR, MSB-out, stepping only when adv is high.
module prbs_gen #(
  parameter int unsigned   W    = 7,
  parameter int unsigned   TAP  = 5,
  parameter logic [W-1:0]  SEED = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adv,
  output logic msb
);

  logic [W-1:0] s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   s <= SEED;
    else if (adv) s <= {s[W-2:0], s[W-1] ^ s[TAP]};
  end

  assign msb = s[W-1];

endmodule

// File: rtl/nrz_symbol_tx.sv
// NRZ symbol generator: fractional NCO symbol timing, selectable pattern
// source, error injection and a 2-tap post-cursor FIR into 8-bit samples.
module nrz_symbol_tx
  import cdr_pkg::*;
#(
  parameter int unsigned          PHASE_BITS  = 32,
  parameter logic [PRBS7_W-1:0]   PRBS7_SEED  = PRBS7_SEED_DEF,
  parameter logic [PRBS15_W-1:0]  PRBS15_SEED = PRBS15_SEED_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  nrz_symbol_tx_if.slave  bus
);

  logic [PHASE_BITS-1:0] phase;
  logic [PHASE_BITS:0]   add;
  logic                  boundary;
  logic                  p7_bit, p15_bit;
  logic                  clk_q;
  logic [3:0]            idx;
  logic                  pending;
  logic                  prev_valid;
  logic                  src_bit, new_bit;
  logic                  sym_en_q, tx_bit_q;
  logic signed [SAMPLE_W-1:0] y_q;
  logic signed [ACC_W-1:0] amp_s, c1_s, main_v, prev_v, post_v, y_v;

  // Symbol boundary is the NCO carry-out
  assign add      = {1'b0, phase} + {1'b0, bus.fcw};
  assign boundary = bus.en & add[PHASE_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      phase <= '0;
    else if (bus.en) phase <= add[PHASE_BITS-1:0];
  end

  prbs_gen #(.W(PRBS7_W), .TAP(PRBS7_TAP), .SEED(PRBS7_SEED)) u_prbs7 (
    .clk(clk), .rst_n(rst_n),
    .adv(boundary && (bus.pat_sel == PAT_PRBS7)), .msb(p7_bit)
  );

  prbs_gen #(.W(PRBS15_W), .TAP(PRBS15_TAP), .SEED(PRBS15_SEED)) u_prbs15 (
    .clk(clk), .rst_n(rst_n),
    .adv(boundary && (bus.pat_sel == PAT_PRBS15)), .msb(p15_bit)
  );

  // Clock source emits the post-toggle value so the first bit is 1
  always_comb begin
    src_bit = p7_bit;
    case (bus.pat_sel)
      PAT_PRBS7:  src_bit = p7_bit;
      PAT_PRBS15: src_bit = p15_bit;
      PAT_CLOCK:  src_bit = ~clk_q;
      PAT_FIXED:  src_bit = bus.fix_word[idx];
      default:    src_bit = p7_bit;
    endcase
    new_bit = src_bit ^ (pending | bus.inj_err);
  end

  // Main cursor plus floored post-cursor; tx_bit_q holds the previous symbol
  always_comb begin
    amp_s  = ACC_W'(bus.amp);
    c1_s   = ACC_W'(bus.c1);
    main_v = new_bit ? amp_s : -amp_s;
    prev_v = '0;
    if (prev_valid) prev_v = tx_bit_q ? amp_s : -amp_s;
    post_v = (c1_s * prev_v) >>> 3;
    y_v    = main_v + post_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_q      <= 1'b0;
      idx        <= 4'd15;
      pending    <= 1'b0;
      prev_valid <= 1'b0;
      sym_en_q   <= 1'b0;
      tx_bit_q   <= 1'b0;
      y_q        <= '0;
    end else begin
      sym_en_q <= boundary;
      if (boundary) begin
        tx_bit_q   <= new_bit;
        y_q        <= sat_sample(y_v);
        prev_valid <= 1'b1;
        pending    <= 1'b0;
        if (bus.pat_sel == PAT_CLOCK) clk_q <= ~clk_q;
        if (bus.pat_sel == PAT_FIXED) idx   <= idx - 4'd1;
      end else if (bus.inj_err) begin
        pending <= 1'b1;
      end
    end
  end

  assign bus.sym_en = sym_en_q;
  assign bus.tx_bit = tx_bit_q;
  assign bus.y_n    = y_q;

endmodule

// File: tb/tb_nrz_symbol_tx.sv
// Scoreboard bench for nrz_symbol_tx: a behavioural model queues the expected
// symbols each cycle; they are popped and compared whenever sym_en is seen.
module tb_nrz_symbol_tx;
  import cdr_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nrz_symbol_tx_if #(.PHASE_BITS(32)) bus ();
  nrz_symbol_tx #(.PHASE_BITS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  longint m_phase;
  int     m_p7, m_p15, m_idx, m_dprev;
  bit     m_clk, m_pend, m_pv;
  int     q_b[$];
  int     q_y[$];
  int     last_b, last_y;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_p7 = 'h7F; m_p15 = 'h7FFF; m_idx = 15;
    m_clk = 0; m_pend = 0; m_pv = 0; m_dprev = 0;
    q_b.delete(); q_y.delete();
    last_b = 0; last_y = 0;
  endtask

  function automatic bit next_is_boundary();
    return bus.en && ((m_phase + longint'(bus.fcw)) >= 64'h1_0000_0000);
  endfunction

  // One clock of reference behaviour using the inputs currently driven
  task automatic model_step(output bit sym);
    int b, d, y, post, c1i;
    sym = 0;
    if (bus.en) begin
      m_phase = m_phase + longint'(bus.fcw);
      if (m_phase >= 64'h1_0000_0000) begin
        m_phase = m_phase - 64'h1_0000_0000;
        sym = 1;
      end
    end
    if (bus.inj_err) m_pend = 1;
    if (sym) begin
      case (bus.pat_sel)
        PAT_PRBS7: begin
          b = (m_p7 >> 6) & 1;
          m_p7 = ((m_p7 << 1) & 'h7F) | (((m_p7 >> 6) ^ (m_p7 >> 5)) & 1);
        end
        PAT_PRBS15: begin
          b = (m_p15 >> 14) & 1;
          m_p15 = ((m_p15 << 1) & 'h7FFF) | (((m_p15 >> 14) ^ (m_p15 >> 13)) & 1);
        end
        PAT_CLOCK: begin
          m_clk = !m_clk;
          b = int'(m_clk);
        end
        default: begin
          b = int'(bus.fix_word[m_idx]);
          m_idx = (m_idx + 15) % 16;
        end
      endcase
      if (m_pend) b = 1 - b;
      m_pend = 0;
      d = (b == 1) ? 1 : -1;
      c1i = bus.c1;
      post = m_pv ? ((c1i * m_dprev * int'(bus.amp)) >>> 3) : 0;
      y = d * int'(bus.amp) + post;
      if (y > 127)  y = 127;
      if (y < -128) y = -128;
      m_dprev = d;
      m_pv = 1;
      q_b.push_back(b);
      q_y.push_back(y);
    end
  endtask

  task automatic tick();
    bit e;
    int yv;
    model_step(e);
    @(posedge clk);
    #1;
    yv = bus.y_n;
    chk("sym_en", int'(bus.sym_en), int'(e));
    if (bus.sym_en) begin
      if (q_b.size() == 0) begin
        chk("scoreboard_underflow", 1, 0);
      end else begin
        last_b = q_b.pop_front();
        last_y = q_y.pop_front();
        chk("tx_bit", int'(bus.tx_bit), last_b);
        chk("y_n", yv, last_y);
      end
    end else begin
      chk("hold_tx_bit", int'(bus.tx_bit), last_b);
      chk("hold_y_n", yv, last_y);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    int yv;
    rst_n = 1'b0;
    #1;
    yv = bus.y_n;
    chk("rst_sym_en", int'(bus.sym_en), 0);
    chk("rst_tx_bit", int'(bus.tx_bit), 0);
    chk("rst_y_n", yv, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic pulse_inj();
    bus.inj_err = 1'b1;
    tick();
    bus.inj_err = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.fcw      = 32'h4000_0000;
    bus.pat_sel  = PAT_PRBS7;
    bus.fix_word = 16'hF000;
    bus.amp      = 7'd64;
    bus.c1       = 4'sd0;
    bus.inj_err  = 1'b0;
    #2;
    do_reset();

    // PRBS7 over more than one full period
    bus.en = 1'b1;
    run(4 * 130);

    // Clock pattern with de-emphasis
    bus.pat_sel = PAT_CLOCK;
    bus.c1      = -4'sd2;
    do_reset();
    run(40);

    // Fixed word with saturating post-cursor
    bus.pat_sel = PAT_FIXED;
    bus.amp     = 7'd127;
    bus.c1      = 4'sd7;
    do_reset();
    run(4 * 36);

    // PRBS15 with error injection mid-symbol, repeated, and on a boundary
    bus.pat_sel = PAT_PRBS15;
    bus.amp     = 7'd64;
    bus.c1      = 4'sd3;
    run(6);
    while (next_is_boundary()) tick();
    pulse_inj();
    run(12);
    while (next_is_boundary()) tick();
    bus.inj_err = 1'b1;
    tick();
    while (next_is_boundary()) tick();
    tick();
    bus.inj_err = 1'b0;
    run(8);
    while (!next_is_boundary()) tick();
    pulse_inj();
    run(20);

    // Enable gap freezes phase and outputs
    run(5);
    bus.en = 1'b0;
    run(10);
    bus.en = 1'b1;
    run(20);

    // Asynchronous reset mid-symbol, PRBS15 restarts from seed
    while (!next_is_boundary()) tick();
    tick();
    tick();
    do_reset();
    run(4 * 20);

    // Maximum fcw and pattern switching with held generator state
    bus.fcw     = 32'hFFFF_FFFF;
    bus.pat_sel = PAT_PRBS7;
    bus.c1      = 4'sd0;
    do_reset();
    run(30);
    bus.pat_sel = PAT_PRBS15;
    run(10);
    bus.pat_sel = PAT_PRBS7;
    run(30);

    chk("scoreboard_drained", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
